// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory port arbiter; sizing helpers for the optional
// starvation guard (ARB_STARVE_GUARD_EN).
package mem_arb_pkg;

   localparam int unsigned STARVE_LIMIT_DFLT = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2,
      RESP  = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;

   function automatic int unsigned starve_cnt_w(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

   localparam int unsigned STARVE_CNT_W = $clog2(STARVE_LIMIT_DFLT + 1);

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of D grants taken while a fetch waits; raises force_i_c at LIMIT.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned LIMIT = STARVE_LIMIT_DFLT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_grant,
   input  logic i_pend,
   input  logic i_grant,
   output logic force_i_c
);

   localparam int unsigned CNT_W = starve_cnt_w(LIMIT);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (i_grant) begin
         cnt <= '0;
      end else if (d_grant && i_pend && (cnt != CNT_W'(LIMIT))) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign force_i_c = (cnt == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported variable-latency memory between fetch (I) and data (D).
// D has priority; define ARB_STARVE_GUARD_EN to force an I grant after STARVE_LIMIT D grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_ack_o,
   output logic [DATA_W-1:0] if_rdata_o,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic              d_ack_o,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              busy_o
);

   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

   if (STARVE_LIMIT == 0) begin : g_limit_chk
      $error("STARVE_LIMIT must be at least 1");
   end

   arb_state_t state;
   owner_t     win_c;
   logic       win_vld_c;
   logic       force_i_c;

   // Grant decision, only meaningful in IDLE
   always_comb begin
      win_vld_c = 1'b0;
      win_c     = OWN_I;
      if (state == IDLE) begin
         if (d_req_i && !(force_i_c && if_req_i)) begin
            win_vld_c = 1'b1;
            win_c     = OWN_D;
         end else if (if_req_i) begin
            win_vld_c = 1'b1;
            win_c     = OWN_I;
         end
      end
   end

`ifdef ARB_STARVE_GUARD_EN
   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk       (clk_i),
      .rst_n     (rst_i),
      .d_grant   (win_vld_c && (win_c == OWN_D)),
      .i_pend    (if_req_i),
      .i_grant   (win_vld_c && (win_c == OWN_I)),
      .force_i_c (force_i_c)
   );
`else
   assign force_i_c = 1'b0;
`endif

   // Arbitration FSM with registered memory-side and requester-side outputs
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state       <= IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_ack_o    <= 1'b0;
         d_ack_o     <= 1'b0;
         if_rdata_o  <= '0;
         d_rdata_o   <= '0;
         busy_o      <= 1'b0;
      end else begin
         if_ack_o <= 1'b0;
         d_ack_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (win_vld_c) begin
                  mem_req_o <= 1'b1;
                  busy_o    <= 1'b1;
                  if (win_c == OWN_D) begin
                     state       <= GNT_D;
                     mem_we_o    <= d_we_i;
                     mem_addr_o  <= d_addr_i & WORD_MASK;
                     mem_wdata_o <= d_wdata_i;
                  end else begin
                     state       <= GNT_I;
                     mem_we_o    <= 1'b0;
                     mem_addr_o  <= if_addr_i & WORD_MASK;
                     mem_wdata_o <= '0;
                  end
               end
            end
            GNT_I: begin
               if (mem_ack_i) begin
                  state      <= RESP;
                  mem_req_o  <= 1'b0;
                  if_ack_o   <= 1'b1;
                  if_rdata_o <= mem_rdata_i;
               end
            end
            GNT_D: begin
               if (mem_ack_i) begin
                  state     <= RESP;
                  mem_req_o <= 1'b0;
                  d_ack_o   <= 1'b1;
                  d_rdata_o <= mem_rdata_i;
               end
            end
            RESP: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               mem_req_o <= 1'b0;
               busy_o    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory responder
// and an expected-ack scoreboard; expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic          clk;
   logic          rst_i;
   logic          if_req_i;
   logic [AW-1:0] if_addr_i;
   logic          if_ack_o;
   logic [DW-1:0] if_rdata_o;
   logic          d_req_i;
   logic          d_we_i;
   logic [AW-1:0] d_addr_i;
   logic [DW-1:0] d_wdata_i;
   logic          d_ack_o;
   logic [DW-1:0] d_rdata_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_ack_i;
   logic [DW-1:0] mem_rdata_i;
   logic          busy_o;

   mem_port_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (4)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_ack_o    (if_ack_o),
      .if_rdata_o  (if_rdata_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_ack_o     (d_ack_o),
      .d_rdata_o   (d_rdata_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_d;
      bit          dc;
      logic [31:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   mem_auto = 1'b1;
   bit   man_ack  = 1'b0;
   int   mem_lat  = 1;

   function automatic logic [31:0] mem_model(input logic [31:0] a);
      return a ^ 32'h5A5A_C3C3;
   endfunction

   // Memory responder: ack mem_lat cycles after mem_req_o rises, or manual pulses
   initial begin : responder
      int cnt;
      cnt         = 0;
      mem_ack_i   = 1'b0;
      mem_rdata_i = '0;
      forever begin
         @(posedge clk);
         #2;
         mem_rdata_i = mem_model(mem_addr_o);
         if (mem_auto) begin
            if (mem_req_o) begin
               if (cnt >= mem_lat) begin
                  mem_ack_i = 1'b1;
                  cnt       = 0;
               end else begin
                  mem_ack_i = 1'b0;
                  cnt++;
               end
            end else begin
               mem_ack_i = 1'b0;
               cnt       = 0;
            end
         end else begin
            mem_ack_i = man_ack;
            cnt       = 0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit is_d, input bit dc, input logic [31:0] rdata);
      exp_t e;
      e.is_d  = is_d;
      e.dc    = dc;
      e.rdata = rdata;
      exp_q.push_back(e);
   endtask

   // Wait for the next ack, compare it against the scoreboard head
   task automatic wait_ack(input string tag, input int budget,
                           output int n, output int req_cyc, output bit unstable);
      exp_t        e;
      bit          got;
      logic [31:0] a0;
      n        = 0;
      req_cyc  = 0;
      unstable = 1'b0;
      got      = 1'b0;
      a0       = '0;
      while (!got && (n < budget)) begin
         @(negedge clk);
         n++;
         if (mem_req_o) begin
            if (req_cyc == 0) a0 = mem_addr_o;
            else if (mem_addr_o !== a0) unstable = 1'b1;
            req_cyc++;
         end
         if (if_ack_o || d_ack_o) begin
            got = 1'b1;
            if (exp_q.size() == 0) begin
               check({tag, "_unexpected_ack"}, 32'({if_ack_o, d_ack_o}), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check({tag, "_ack_port"}, 32'({if_ack_o, d_ack_o}), e.is_d ? 32'd1 : 32'd2);
               if (!e.dc)
                  check({tag, "_rdata"}, e.is_d ? d_rdata_o : if_rdata_o, e.rdata);
            end
         end
      end
      check({tag, "_ack_seen"}, 32'(got), 32'd1);
   endtask

   initial begin : stim
      int n;
      int rc;
      bit us;

      rst_i     = 1'b0;
      if_req_i  = 1'b0;
      if_addr_i = '0;
      d_req_i   = 1'b0;
      d_we_i    = 1'b0;
      d_addr_i  = '0;
      d_wdata_i = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", 32'(mem_req_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_acks", 32'({if_ack_o, d_ack_o}), 32'd0);
      check("rst_mem_addr", mem_addr_o, 32'd0);
      check("rst_if_rdata", if_rdata_o, 32'd0);
      check("rst_d_rdata", d_rdata_o, 32'd0);
      rst_i = 1'b1;
      @(negedge clk);

      // Single fetch, memory latency 1
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0010;
      push(1'b0, 1'b0, mem_model(32'h0000_0010));
      @(negedge clk);
      check("t1_mem_req", 32'(mem_req_o), 32'd1);
      check("t1_mem_addr", mem_addr_o, 32'h0000_0010);
      check("t1_mem_we", 32'(mem_we_o), 32'd0);
      check("t1_busy", 32'(busy_o), 32'd1);
      wait_ack("t1", 20, n, rc, us);
      check("t1_latency", 32'(n + 1), 32'd3);
      if_req_i = 1'b0;
      @(negedge clk);

      // Simultaneous I and D: D store wins, then I
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0040;
      d_req_i   = 1'b1;
      d_we_i    = 1'b1;
      d_addr_i  = 32'h0000_0104;
      d_wdata_i = 32'hDEAD_BEEF;
      push(1'b1, 1'b1, '0);
      push(1'b0, 1'b0, mem_model(32'h0000_0040));
      @(negedge clk);
      check("t2_mem_we", 32'(mem_we_o), 32'd1);
      check("t2_mem_addr", mem_addr_o, 32'h0000_0104);
      check("t2_mem_wdata", mem_wdata_o, 32'hDEAD_BEEF);
      wait_ack("t2_d", 20, n, rc, us);
      d_req_i = 1'b0;
      d_we_i  = 1'b0;
      wait_ack("t2_i", 20, n, rc, us);
      if_req_i = 1'b0;
      @(negedge clk);

      // D load with memory latency 5
      mem_lat  = 5;
      d_req_i  = 1'b1;
      d_we_i   = 1'b0;
      d_addr_i = 32'h0000_0208;
      push(1'b1, 1'b0, mem_model(32'h0000_0208));
      wait_ack("t3", 20, n, rc, us);
      d_req_i = 1'b0;
      check("t3_latency", 32'(n), 32'd7);
      check("t3_req_cycles", 32'(rc), 32'd6);
      check("t3_addr_stable", 32'(us), 32'd0);
      @(negedge clk);
      check("t3_ack_one_cycle", 32'(d_ack_o), 32'd0);
      repeat (3) @(negedge clk);
      check("t3_rdata_hold", d_rdata_o, mem_model(32'h0000_0208));
      mem_lat = 1;

      // Spurious mem_ack_i while IDLE
      mem_auto = 1'b0;
      man_ack  = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
      check("t4_acks", 32'({if_ack_o, d_ack_o}), 32'd0);
      check("t4_busy", 32'(busy_o), 32'd0);
      check("t4_mem_req", 32'(mem_req_o), 32'd0);
      @(negedge clk);
      check("t4_busy_later", 32'(busy_o), 32'd0);

      // Reset in the middle of a D grant, then a late mem ack
      d_req_i  = 1'b1;
      d_we_i   = 1'b0;
      d_addr_i = 32'h0000_0300;
      @(negedge clk);
      check("t5_mem_req", 32'(mem_req_o), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_i = 1'b0;
      @(negedge clk);
      check("t5_rst_mem_req", 32'(mem_req_o), 32'd0);
      check("t5_rst_busy", 32'(busy_o), 32'd0);
      check("t5_rst_d_ack", 32'(d_ack_o), 32'd0);
      check("t5_rst_d_rdata", d_rdata_o, 32'd0);
      rst_i   = 1'b1;
      d_req_i = 1'b0;
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      @(negedge clk);
      check("t5_late_acks", 32'({if_ack_o, d_ack_o}), 32'd0);
      check("t5_late_busy", 32'(busy_o), 32'd0);
      mem_auto  = 1'b1;
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0333;
      push(1'b0, 1'b0, mem_model(32'h0000_0330));
      wait_ack("t5_fresh", 20, n, rc, us);
      if_req_i = 1'b0;
      check("t5_fresh_latency", 32'(n), 32'd3);
      @(negedge clk);

      // Both requesters held high continuously
      if_req_i  = 1'b1;
      if_addr_i = 32'h0000_0500;
      d_req_i   = 1'b1;
      d_we_i    = 1'b0;
      d_addr_i  = 32'h0000_0600;
      for (int g = 0; g < 10; g++) begin
`ifdef ARB_STARVE_GUARD_EN
         if ((g % 5) == 4) push(1'b0, 1'b0, mem_model(32'h0000_0500));
         else              push(1'b1, 1'b0, mem_model(32'h0000_0600));
`else
         push(1'b1, 1'b0, mem_model(32'h0000_0600));
`endif
         wait_ack($sformatf("t6_g%0d", g), 20, n, rc, us);
      end
      if_req_i = 1'b0;
      d_req_i  = 1'b0;
      repeat (3) @(negedge clk);
      check("t6_idle_busy", 32'(busy_o), 32'd0);
      check("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
